serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//  Serial-in / parallel-out shift receiver, the inverse of the multi-mode shift register.
//  Collects WIDTH data bits (plus an optional parity bit) from a one-bit stream, MSB- or LSB-first.
//  Presents the assembled word on a valid/ready handshake.
//  Sits between a serial link (or the shifter's serial output) and a parallel consumer.
// PARAMETERS
//  WIDTH       4  data bits per frame (>=2)
//  PARITY_EN   1  1: one parity bit follows the data bits; 0: no parity bit
//  ODD_PARITY  0  1: odd parity expected; 0: even parity expected (data bits + parity bit)
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  rst         in   1      synchronous, active-high reset
//  sin         in   1      serial data bit
//  sin_valid   in   1      sin carries a bit this cycle
//  msb_first   in   1      bit order; sampled only on the first bit of a frame
//  outp        out  WIDTH  assembled word; stable while out_valid=1
//  out_valid   out  1      word available
//  out_ready   in   1      consumer accepts word (handshake = out_valid & out_ready)
//  parity_err  out  1      parity mismatch for current outp; meaningful only while out_valid; 0 if PARITY_EN=0
//  overrun     out  1      sticky: a bit arrived in HOLD without a handshake; clears on next handshake
//  busy        out  1      1 in SHIFT or PAR state
// BEHAVIOUR
//  Reset: state=IDLE, shreg=0, bitcnt=0, outp=0, out_valid=0, parity_err=0, overrun=0, busy=0.
//  Reset wins over everything. Mid-frame reset discards the partial word and drops a pending word.
//  States: IDLE, SHIFT, PAR, HOLD.
//  IDLE: on sin_valid, latch msb_first into order_q, shift first bit in, bitcnt=1, go to SHIFT.
//  SHIFT: on each sin_valid, shift bit in and bitcnt++. Cycles without sin_valid hold state (gaps allowed).
//    On the WIDTH-th bit: if PARITY_EN, go to PAR; else load outp with the final word and go to HOLD.
//  Shift rules (outp and shreg are WIDTH bits wide):
//    MSB-first: shreg <= {shreg[WIDTH-2:0], sin}
//    LSB-first: shreg <= {sin, shreg[WIDTH-1:1]}
//  PAR: on sin_valid, outp <= shreg.
//    parity_err <= (^shreg ^ sin) != ODD_PARITY. Go to HOLD.
//  HOLD: out_valid=1; outp and parity_err are held.
//    Handshake: out_valid falls next cycle and overrun clears.
//      Next state IDLE, or SHIFT if sin_valid in the same cycle (that bit becomes bit 0 of the new frame).
//    sin_valid without handshake: bit dropped, overrun <= 1, state stays HOLD.
//  Latency: out_valid rises the cycle after the last frame bit (data bit, or parity bit if PARITY_EN) is sampled.
//    Back-to-back frames are supported at 1 bit/cycle when out_ready=1.
//  bitcnt is clog2(WIDTH+1) wide and is cleared on entry to IDLE and on handshake.
// TESTING
//  1. WIDTH=4, PARITY_EN=0, msb_first=1, sin 1,0,1,1 on consecutive cycles
//     -> out_valid on cycle 4, outp=4'b1011.
//  2. Same bits with msb_first=0 -> outp=4'b1101.
//     Toggling msb_first mid-frame has no effect.
//  3. PARITY_EN=1, even parity, data 1011 MSB-first then parity 1 -> parity_err=0.
//     Repeat with parity 0 -> parity_err=1.
//  4. Word in HOLD, out_ready=0, two sin_valid bits -> overrun=1, outp unchanged.
//     Then handshake -> overrun=0, state IDLE.
//  5. Handshake and sin_valid=1 in the same cycle, then 3 more bits
//     -> second word valid 4 cycles later, no overrun.
//  6. rst=1 after 2 of 4 bits -> all outputs 0.
//     The next 4 bits form a fresh word with no residue from the old frame.

Source files
------------

// File: rtl/serial_word_receiver_if.sv
// Bundle of the serial-in and parallel-out handshake signals of serial_word_receiver.
//   sin/sin_valid/msb_first : serial bit stream from the link (master -> slave)
//   out_ready               : consumer accepts the word (master -> slave)
//   outp/out_valid          : assembled word and its valid flag (slave -> master)
//   parity_err/overrun/busy : frame status (slave -> master)
interface serial_word_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             msb_first;
  logic             out_ready;
  logic [WIDTH-1:0] outp;
  logic             out_valid;
  logic             parity_err;
  logic             overrun;
  logic             busy;

  // Link/consumer side
  modport master (
    output sin, sin_valid, msb_first, out_ready,
    input  outp, out_valid, parity_err, overrun, busy
  );

  // Receiver side
  modport slave (
    input  sin, sin_valid, msb_first, out_ready,
    output outp, out_valid, parity_err, overrun, busy
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-in / parallel-out frame receiver. Collects WIDTH data bits (plus an
// optional parity bit) MSB- or LSB-first and presents the word on a
// valid/ready handshake.
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : serial_word_receiver_if.slave (serial input, word output, status)
module serial_word_receiver #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_word_receiver_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    bitcnt, bitcnt_d;
  logic             order_q, order_d;
  logic [WIDTH-1:0] outp_q, outp_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, busy_q;

  // Both candidate shifts of the current shift register
  logic [WIDTH-1:0] sh_msb, sh_lsb;
  assign sh_msb = {shreg[WIDTH-2:0], bus.sin};
  assign sh_lsb = {bus.sin, shreg[WIDTH-1:1]};

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    order_d  = order_q;
    outp_d   = outp_q;
    perr_d   = perr_q;
    ovr_d    = ovr_q;
    case (state)
      IDLE: begin
        if (bus.sin_valid) begin
          order_d  = bus.msb_first;
          shreg_d  = bus.msb_first ? sh_msb : sh_lsb;
          bitcnt_d = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          shreg_d  = order_q ? sh_msb : sh_lsb;
          bitcnt_d = bitcnt + CW'(1);
          if (bitcnt == CW'(WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PAR;
            end else begin
              outp_d  = order_q ? sh_msb : sh_lsb;
              state_d = HOLD;
            end
          end
        end
      end
      PAR: begin
        if (bus.sin_valid) begin
          outp_d  = shreg;
          perr_d  = ((^shreg) ^ bus.sin) != 1'(ODD_PARITY);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          ovr_d    = 1'b0;
          bitcnt_d = '0;
          if (bus.sin_valid) begin
            // Bit arriving with the handshake starts the next frame
            order_d  = bus.msb_first;
            shreg_d  = bus.msb_first ? sh_msb : sh_lsb;
            bitcnt_d = CW'(1);
            state_d  = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.sin_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      order_q <= 1'b0;
      outp_q  <= '0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bitcnt  <= bitcnt_d;
      order_q <= order_d;
      outp_q  <= outp_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      valid_q <= (state_d == HOLD);
      busy_q  <= (state_d == SHIFT) || (state_d == PAR);
    end
  end

  assign bus.outp       = outp_q;
  assign bus.out_valid  = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // if0: no parity; if1: even parity
  serial_word_receiver_if #(.WIDTH(4)) if0 ();
  serial_word_receiver_if #(.WIDTH(4)) if1 ();

  serial_word_receiver #(.WIDTH(4), .PARITY_EN(0), .ODD_PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  serial_word_receiver #(.WIDTH(4), .PARITY_EN(1), .ODD_PARITY(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int sel, input logic s, input logic v, input logic m, input logic r);
    if (sel == 0) begin
      if0.sin = s; if0.sin_valid = v; if0.msb_first = m; if0.out_ready = r;
    end else begin
      if1.sin = s; if1.sin_valid = v; if1.msb_first = m; if1.out_ready = r;
    end
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_outp",  32'(if0.outp), 32'h0);
    chk("rst_valid", 32'(if0.out_valid), 32'h0);
    chk("rst_perr",  32'(if1.parity_err), 32'h0);
    chk("rst_ovr",   32'(if0.overrun), 32'h0);
    chk("rst_busy",  32'(if0.busy), 32'h0);
    rst = 1'b0;

    // 1: MSB-first 1,0,1,1
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 0, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    chk("t1_busy3",  32'(if0.busy), 32'h1);
    chk("t1_valid3", 32'(if0.out_valid), 32'h0);
    drv(0, 1, 1, 1, 0); tick();
    chk("t1_valid", 32'(if0.out_valid), 32'h1);
    chk("t1_outp",  32'(if0.outp), 32'hB);
    chk("t1_busy",  32'(if0.busy), 32'h0);
    drv(0, 0, 0, 0, 1); tick();
    chk("t1_hs_valid", 32'(if0.out_valid), 32'h0);

    // 2: LSB-first 1,0,1,1 with msb_first toggled after the first bit
    drv(0, 1, 1, 0, 0); tick();
    drv(0, 0, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 1, 1, 0, 0); tick();
    chk("t2_valid", 32'(if0.out_valid), 32'h1);
    chk("t2_outp",  32'(if0.outp), 32'hD);
    drv(0, 0, 0, 0, 1); tick();
    drv(0, 0, 0, 0, 0);

    // 3: even parity, data 1011 MSB-first, parity 1 then parity 0
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 0, 1, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    chk("t3_par_valid", 32'(if1.out_valid), 32'h0);
    chk("t3_par_busy",  32'(if1.busy), 32'h1);
    drv(1, 1, 1, 1, 0); tick();
    chk("t3a_valid", 32'(if1.out_valid), 32'h1);
    chk("t3a_outp",  32'(if1.outp), 32'hB);
    chk("t3a_perr",  32'(if1.parity_err), 32'h0);
    drv(1, 0, 0, 0, 1); tick();
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 0, 1, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 1, 1, 1, 0); tick();
    drv(1, 0, 1, 1, 0); tick();
    chk("t3b_valid", 32'(if1.out_valid), 32'h1);
    chk("t3b_perr",  32'(if1.parity_err), 32'h1);
    drv(1, 0, 0, 0, 1); tick();
    chk("t3b_hs_valid", 32'(if1.out_valid), 32'h0);
    drv(1, 0, 0, 0, 0);

    // 4: overrun while holding
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 0, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    chk("t4_ovr0", 32'(if0.overrun), 32'h0);
    drv(0, 0, 1, 1, 0); tick();
    chk("t4_ovr1", 32'(if0.overrun), 32'h1);
    drv(0, 1, 1, 1, 0); tick();
    chk("t4_ovr2",  32'(if0.overrun), 32'h1);
    chk("t4_outp",  32'(if0.outp), 32'hB);
    chk("t4_valid", 32'(if0.out_valid), 32'h1);
    drv(0, 0, 0, 0, 1); tick();
    chk("t4_hs_ovr",   32'(if0.overrun), 32'h0);
    chk("t4_hs_valid", 32'(if0.out_valid), 32'h0);
    chk("t4_hs_busy",  32'(if0.busy), 32'h0);

    // 5: handshake with a new first bit in the same cycle
    drv(0, 0, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 0, 1, 1, 0); tick();
    chk("t5a_outp", 32'(if0.outp), 32'h6);
    drv(0, 1, 1, 1, 1); tick();
    chk("t5_hs_valid", 32'(if0.out_valid), 32'h0);
    chk("t5_hs_busy",  32'(if0.busy), 32'h1);
    drv(0, 0, 1, 1, 1); tick();
    drv(0, 0, 1, 1, 1); tick();
    drv(0, 1, 1, 1, 1); tick();
    chk("t5b_valid", 32'(if0.out_valid), 32'h1);
    chk("t5b_outp",  32'(if0.outp), 32'h9);
    chk("t5b_ovr",   32'(if0.overrun), 32'h0);
    drv(0, 0, 0, 0, 1); tick();
    chk("t5b_hs_valid", 32'(if0.out_valid), 32'h0);

    // 6: reset mid-frame, then a fresh frame
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    chk("t6_busy", 32'(if0.busy), 32'h1);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0); tick();
    chk("t6_rst_outp",  32'(if0.outp), 32'h0);
    chk("t6_rst_valid", 32'(if0.out_valid), 32'h0);
    chk("t6_rst_busy",  32'(if0.busy), 32'h0);
    chk("t6_rst_ovr",   32'(if0.overrun), 32'h0);
    rst = 1'b0;
    drv(0, 0, 1, 1, 0); tick();
    drv(0, 1, 1, 1, 0); tick();
    drv(0, 0, 1, 1, 0); tick();
    chk("t6_valid3", 32'(if0.out_valid), 32'h0);
    drv(0, 0, 1, 1, 0); tick();
    chk("t6_valid", 32'(if0.out_valid), 32'h1);
    chk("t6_outp",  32'(if0.outp), 32'h4);
    drv(0, 0, 0, 0, 1); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
